// File: rtl/shared_reg_write_arbiter.sv
// Arbitrates the write port of one WIDTH-bit register among NUM_REQ requesters,
// using fixed priority or round-robin, with a programmable hold window after each write.
module shared_reg_write_arbiter #(
    parameter int                NUM_REQ     = 4,
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                HOLD_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     rr_mode,
    output logic [WIDTH-1:0]         out,
    output logic                     update,
    output logic [2:0]               grant_idx,
    output logic                     busy
);

    // Handshake: a requester's write transfers on the rising edge where
    // req_valid[i] & req_ready[i] are both 1. req_ready is a combinational
    // function of req_valid, so req_valid must never depend on req_ready.

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [2:0]       rr_ptr;
    logic [2:0]       winner;
    logic [2:0]       win_fixed, win_hi, win_lo;
    logic             found_hi;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    // Descending scans: the last hit is the lowest index, so win_hi is the
    // lowest valid index at or above rr_ptr and win_lo the lowest overall.
    always_comb begin
        win_fixed = '0;
        win_hi    = '0;
        win_lo    = '0;
        found_hi  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) win_fixed = 3'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_lo = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    win_hi   = 3'(i);
                    found_hi = 1'b1;
                end
            end
        end
        if (rr_mode) winner = found_hi ? win_hi : win_lo;
        else         winner = win_fixed;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == winner) sel_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign transfer  = (state == IDLE) && (|req_valid);
    assign req_ready = transfer ? (NUM_REQ'(1) << winner) : '0;
    assign busy      = (state == HOLD);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (transfer && HOLD_CYCLES > 0) begin
                    state_next = HOLD;
                    cnt_next   = 4'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            out       <= RESET_VALUE;
            update    <= 1'b0;
            grant_idx <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            update <= transfer;
            if (transfer) begin
                out       <= sel_data;
                grant_idx <= winner;
                rr_ptr    <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
            end
        end
    end

endmodule
